// File: rtl/moving_mean.sv
// ---------------------------------------------------------------------------
// moving_mean
//   Sliding-window mean over the last 2^LOG2_DEPTH accepted samples.
//   Signed or unsigned arithmetic is chosen at run time by 'sign'. The design
//   keeps a circular sample buffer, a running accumulator and a fill count.
//   The result appears one cycle after each accepted sample.
//
//   Optional build macro: MOVING_MEAN_ROUND_EN
//     defined   -> round half toward +inf before the divide-by-DEPTH shift
//     undefined -> truncating shift (rounds toward -inf)
//
// Parameters
//   WIDTH       sample / result width
//   LOG2_DEPTH  log2 of window depth (1..10)
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset
//   clear   in   synchronous flush of window state (dout holds)
//   sign    in   1 = two's-complement samples, 0 = unsigned
//   ivalid  in   sample strobe
//   din     in   sample [WIDTH]
//   dout    out  window mean [WIDTH]
//   ovalid  out  dout strobe, one cycle after each accepted sample
//   full    out  window holds DEPTH samples
// ---------------------------------------------------------------------------
module moving_mean #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             sign,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ovalid,
    output logic             full
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int AW    = WIDTH + LOG2_DEPTH;  // accumulator width
    localparam int CW    = LOG2_DEPTH + 1;      // count must reach DEPTH

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEPTH - 1);

    // Sample storage. Never reset; count_q gates every read so stale
    // contents never reach the accumulator.
    logic [WIDTH-1:0] sample_mem [DEPTH];

    logic [AW-1:0]         acc_q,    acc_d;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic [WIDTH-1:0]      dout_q,   dout_d;
    logic                  ovalid_q, ovalid_d;
    logic                  full_q,   full_d;

    logic                  mem_we;
    logic [AW-1:0]         old_ext;
    logic [AW-1:0]         acc_next;
    logic [WIDTH-1:0]      mean;

    function automatic logic [AW-1:0] ext(input logic [WIDTH-1:0] x,
                                          input logic             s);
        logic fill;
        fill = s & x[WIDTH-1];
        return {{LOG2_DEPTH{fill}}, x};
    endfunction

`ifdef MOVING_MEAN_ROUND_EN
    // One extra bit so adding the half-LSB can never wrap the accumulator.
    localparam logic [AW:0] HALF = (AW+1)'(1) << (LOG2_DEPTH - 1);
    logic [AW:0] acc_wide;
`endif

    always_comb begin
        old_ext = '0;
        if (count_q == COUNT_FULL) begin
            old_ext = ext(sample_mem[wr_ptr_q], sign);
        end
        acc_next = acc_q + ext(din, sign) - old_ext;

        // After dividing by DEPTH the mean always fits in WIDTH bits, so
        // the WIDTH-bit slice above the shift is the same for an arithmetic
        // or a logical shift; only the discarded upper bits would differ.
`ifdef MOVING_MEAN_ROUND_EN
        acc_wide = {sign & acc_next[AW-1], acc_next} + HALF;
        mean     = acc_wide[LOG2_DEPTH +: WIDTH];
`else
        mean     = acc_next[LOG2_DEPTH +: WIDTH];
`endif
    end

    always_comb begin
        acc_d    = acc_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;
        full_d   = full_q;
        mem_we   = 1'b0;

        if (clear) begin
            // Same-cycle sample is dropped; dout keeps the last result.
            acc_d    = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
        end else if (ivalid) begin
            mem_we   = 1'b1;
            acc_d    = acc_next;
            wr_ptr_d = wr_ptr_q + 1'b1;  // natural wrap at DEPTH
            if (count_q != COUNT_FULL) begin
                count_d = count_q + 1'b1;
            end
            dout_d   = mean;
            ovalid_d = 1'b1;
            // Rises together with the ovalid of the DEPTH-th sample.
            if (count_q == COUNT_LAST) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            sample_mem[wr_ptr_q] <= din;
        end
    end

    assign dout   = dout_q;
    assign ovalid = ovalid_q;
    assign full   = full_q;

endmodule

// File: tb/tb_moving_mean.sv
// ---------------------------------------------------------------------------
// tb_moving_mean
//   Directed bench for moving_mean. Two instances share clock and reset:
//   u1 with LOG2_DEPTH=1 and u3 with LOG2_DEPTH=3, both WIDTH=16.
//   Expected values are hand-computed; where rounding changes a result the
//   alternative is selected by MOVING_MEAN_ROUND_EN.
// ---------------------------------------------------------------------------
module tb_moving_mean;

`ifdef MOVING_MEAN_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;

    logic        clr1, sgn1, iv1, ov1, full1;
    logic [15:0] din1, dout1;
    logic        clr3, sgn3, iv3, ov3, full3;
    logic [15:0] din3, dout3;

    int checks = 0;
    int errs   = 0;

    always #5 clock = ~clock;

    moving_mean #(.WIDTH(16), .LOG2_DEPTH(1)) u1 (
        .clock (clock), .reset (reset), .clear (clr1), .sign (sgn1),
        .ivalid(iv1),   .din   (din1),  .dout  (dout1), .ovalid(ov1),
        .full  (full1)
    );

    moving_mean #(.WIDTH(16), .LOG2_DEPTH(3)) u3 (
        .clock (clock), .reset (reset), .clear (clr3), .sign (sgn3),
        .ivalid(iv3),   .din   (din3),  .dout  (dout3), .ovalid(ov3),
        .full  (full3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        int e;
        e = exp & 'hFFFF;
        checks++;
        if (got != e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, e);
        end
    endtask

    // Drive one cycle on an instance, then sample #1 after the edge.
    task automatic s1(input logic v, input logic c, input logic [15:0] d);
        iv1 = v; clr1 = c; din1 = d;
        @(posedge clock); #1;
    endtask

    task automatic s3(input logic v, input logic c, input logic [15:0] d);
        iv3 = v; clr3 = c; din3 = d;
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        clr1 = 0; sgn1 = 1; iv1 = 0; din1 = '0;
        clr3 = 0; sgn3 = 1; iv3 = 0; din3 = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ov1",   int'(ov1),   0);
        chk("rst_dout1", int'(dout1), 0);
        chk("rst_full1", int'(full1), 0);
        chk("rst_ov3",   int'(ov3),   0);
        chk("rst_dout3", int'(dout3), 0);
        chk("rst_full3", int'(full3), 0);
        reset = 1'b0;
        s1(0, 0, 0);

        // Two-tap signed: -31, 11
        sgn1 = 1;
        s1(1, 0, 16'(-31));
        chk("t1_ov_a",   int'(ov1),   1);
        chk("t1_dout_a", int'(dout1), RND ? -15 : -16);
        chk("t1_full_a", int'(full1), 0);
        s1(1, 0, 16'd11);
        chk("t1_ov_b",   int'(ov1),   1);
        chk("t1_dout_b", int'(dout1), -10);
        chk("t1_full_b", int'(full1), 1);
        s1(0, 0, 0);
        chk("t1_ov_idle",   int'(ov1),   0);
        chk("t1_dout_hold", int'(dout1), -10);

        // Unsigned full-scale, then signed -1 after clear
        s1(0, 1, 0);
        chk("t3_full_clr", int'(full1), 0);
        chk("t3_ov_clr",   int'(ov1),   0);
        sgn1 = 0;
        s1(1, 0, 16'hFFFF);
        chk("t3_u_a", int'(dout1), RND ? 'h8000 : 'h7FFF);
        s1(1, 0, 16'hFFFF);
        chk("t3_u_b", int'(dout1), 'hFFFF);
        s1(0, 1, 0);
        sgn1 = 1;
        s1(1, 0, 16'hFFFF);
        chk("t3_s_a", int'(dout1), RND ? 0 : -1);
        s1(1, 0, 16'hFFFF);
        chk("t3_s_b", int'(dout1), -1);

        // Odd sums: 7 and -7
        s1(0, 1, 0);
        s1(1, 0, 16'd3);
        s1(1, 0, 16'd4);
        chk("t4_pos", int'(dout1), RND ? 4 : 3);
        s1(1, 0, 16'(-3));
        s1(1, 0, 16'(-4));
        chk("t4_neg", int'(dout1), RND ? -3 : -4);

        // Clear with same-cycle ivalid mid-fill
        s1(0, 1, 0);
        s1(1, 0, 16'd10);
        chk("t5_pre", int'(dout1), 5);
        s1(1, 1, 16'd99);
        chk("t5_ov_drop",   int'(ov1),   0);
        chk("t5_full_drop", int'(full1), 0);
        chk("t5_dout_hold", int'(dout1), 5);
        s1(1, 0, 16'd10);
        chk("t5_a",      int'(dout1), 5);
        chk("t5_full_a", int'(full1), 0);
        s1(1, 0, 16'd20);
        chk("t5_b",      int'(dout1), 15);
        chk("t5_full_b", int'(full1), 1);
        s1(0, 0, 0);

        // Depth 8: eight 100s, then 900 evicts the oldest
        s3(0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            s3(1, 0, 16'd100);
            if (i == 1) chk("t2_first",  int'(dout3), RND ? 13 : 12);
            if (i == 7) chk("t2_full7",  int'(full3), 0);
            if (i == 8) begin
                chk("t2_eighth", int'(dout3), 100);
                chk("t2_full8",  int'(full3), 1);
            end
        end
        s3(1, 0, 16'd900);
        chk("t2_wrap",    int'(dout3), 200);
        chk("t2_ov_wrap", int'(ov3),   1);
        s3(0, 0, 0);
        chk("t2_ov_idle", int'(ov3),   0);
        chk("t2_hold",    int'(dout3), 200);

        // Reset mid-stream with ivalid held high
        s3(0, 1, 0);
        s3(1, 0, 16'd50);
        s3(1, 0, 16'd50);
        s3(1, 0, 16'd50);
        chk("t6_pre", int'(dout3), RND ? 19 : 18);
        reset = 1'b1;
        s3(1, 0, 16'd50);
        chk("t6_ov_rst",   int'(ov3),   0);
        chk("t6_dout_rst", int'(dout3), 0);
        chk("t6_full_rst", int'(full3), 0);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s3(1, 0, 16'd100);
            if (i == 1) chk("t6_first", int'(dout3), RND ? 13 : 12);
            if (i == 2) chk("t6_second", int'(dout3), 25);
            if (i == 8) begin
                chk("t6_eighth", int'(dout3), 100);
                chk("t6_full8",  int'(full3), 1);
            end
        end
        s3(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/moving_mean.md
Name: moving_mean

Overview:
Parametrised sliding-window mean. It averages the last 2^LOG2_DEPTH valid samples of one input stream, with signed or unsigned arithmetic selectable at run time. It generalises the two-operand mean to a configurable width and window depth, with a circular sample buffer, running accumulator, fill tracking and synchronous flush. It sits in the Basic/Math library, feeding smoothing and DC-estimate paths.

Parameters:
- WIDTH, 16: sample and result width in bits.
- LOG2_DEPTH, 3: log2 of window depth. DEPTH = 2^LOG2_DEPTH; legal range 1..10.

Ports:
- clock, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- clear, input, 1: synchronous flush of window state.
- sign, input, 1: 1 = two's-complement samples; 0 = unsigned samples.
- ivalid, input, 1: din valid strobe; one sample accepted per cycle it is high.
- din, input, WIDTH: sample.
- dout, output, WIDTH: window mean.
- ovalid, output, 1: dout valid strobe.
- full, output, 1: window holds DEPTH samples.

Behaviour:
- Reset (reset=1 at clock edge):
  - acc, wr_ptr and count go to 0.
  - dout, ovalid and full go to 0.
  - Buffer RAM contents are not cleared.
- clear=1: same effect as reset, except dout holds its value. clear has priority over a same-cycle ivalid; that sample is dropped and ovalid=0 next cycle.
- Accumulator width is WIDTH+LOG2_DEPTH. Samples are sign-extended when sign=1 and zero-extended when sign=0.
- On ivalid (with clear and reset low):
  - old = buf[wr_ptr] extended, if count==DEPTH; otherwise old = 0. The buffer is never read before it has been written.
  - acc_next = acc + ext(din) - old.
  - buf[wr_ptr] <= din.
  - wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
  - count increments, saturating at DEPTH.
- Output:
  - Latency is 1 cycle: ovalid is high the cycle after each accepted sample.
  - dout = acc_next >> LOG2_DEPTH, truncated to WIDTH bits. The shift is arithmetic when sign=1 and logical when sign=0, so results round toward minus infinity.
  - The result always fits in WIDTH bits; no saturation is needed.
  - While filling (count<DEPTH), the divisor is still DEPTH. Partial-window results are intentionally scaled low.
  - dout holds its value when ovalid=0.
- full is registered. It rises with the ovalid of the DEPTH-th sample and stays high until reset or clear.
- Back-to-back ivalid on every cycle is supported at full throughput with no bubbles.
- sign must only change while the window is empty (after reset or clear). Otherwise dout is don't-care until the next clear.

Optional Feature:
- Macro: MOVING_MEAN_ROUND_EN.
- Defined: 2^(LOG2_DEPTH-1) is added to acc_next before the shift, giving round-half-up (half toward plus infinity) in both sign modes. The adder stays WIDTH+LOG2_DEPTH+1 bits internally, so there is no overflow.
- Undefined: plain truncating shift, as above.

Test Plan:
1. LOG2_DEPTH=1, sign=1; din -31 then 11 on consecutive cycles -> ovalid pulses on two cycles; second dout = -10; full=1 with the second result.
2. LOG2_DEPTH=3, sign=1; eight samples of 100, then 900:
   - after the 1st sample, dout=12;
   - after the 8th, dout=100 and full=1;
   - after the 9th, dout=200 (wrap evicts the oldest 100).
3. LOG2_DEPTH=1, sign=0; 0xFFFF twice -> dout=0xFFFF. Repeat after clear with sign=1 -> dout=0xFFFF (-1).
4. LOG2_DEPTH=1, sign=1; sum 7 (3,4) and sum -7 (-3,-4):
   - without the macro: dout 3 and -4;
   - with MOVING_MEAN_ROUND_EN: dout 4 and -3.
5. clear asserted together with ivalid mid-fill -> no ovalid next cycle, full=0, count=0. The next 2 samples 10, 20 (LOG2_DEPTH=1) -> dout 5, then 15.
6. reset asserted mid-stream with ivalid held high -> ovalid=0, dout=0, full=0 after the edge. The stream then restarts cleanly; expected values match a fresh run.
